// File: rtl/sd_sector_server.sv
// Fabric-side responder for the hps_io virtual-disk sector protocol: serves 512-byte
// sector reads/writes from a byte-wide backing store in place of the HPS.
//
// state  | meaning
// IDLE   | scan requests, lowest drive wins, read beats write
// DELAY  | count down before raising sd_ack
// RFETCH | fetch one byte from the backing store (or 0x00 when out of range)
// RPUT   | present the byte to the initiator with a single sd_buff_wr strobe
// WADDR  | present sd_buff_addr, initiator returns data one cycle later
// WCAP   | capture the initiator byte into mem_din
// WPUT   | hold mem_wr until the backing store completes
// FIN    | sd_ack and sd_buff_addr cleared, back to IDLE
module sd_sector_server #(
    parameter int VDNUM     = 2,
    parameter int LBA_W     = 15,
    parameter int ACK_DELAY = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [32*VDNUM-1:0]    sd_lba,
    input  logic [VDNUM-1:0]       sd_rd,
    input  logic [VDNUM-1:0]       sd_wr,
    output logic [VDNUM-1:0]       sd_ack,
    output logic [8:0]             sd_buff_addr,
    output logic [7:0]             sd_buff_dout,
    input  logic [8*VDNUM-1:0]     sd_buff_din,
    output logic                   sd_buff_wr,
    input  logic [32*VDNUM-1:0]    img_blocks,
    output logic [2+LBA_W+9-1:0]   mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [7:0]             mem_din,
    input  logic [7:0]             mem_dout,
    input  logic                   mem_ready
);

    localparam int              AW       = 2 + LBA_W + 9;
    localparam int              CW       = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(ACK_DELAY - 1);
    localparam logic [8:0]      LAST     = 9'd511;

    typedef enum logic [2:0] {
        IDLE, DELAY, RFETCH, RPUT, WADDR, WCAP, WPUT, FIN
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         drv, drv_nxt;
    logic               is_rd, is_rd_nxt;
    logic [LBA_W-1:0]   lba, lba_nxt;
    logic               inrange, inrange_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;

    logic [VDNUM-1:0]   sd_ack_nxt;
    logic [8:0]         sd_buff_addr_nxt;
    logic [7:0]         sd_buff_dout_nxt;
    logic               sd_buff_wr_nxt;
    logic [AW-1:0]      mem_addr_nxt;
    logic               mem_rd_nxt;
    logic               mem_wr_nxt;
    logic [7:0]         mem_din_nxt;

    logic               req_any;
    logic [1:0]         req_drv;
    logic               req_rd;
    logic [31:0]        req_lba;
    logic [31:0]        req_img;
    logic [7:0]         din_sel;
    logic [VDNUM-1:0]   drv_onehot;
    logic [8:0]         addr_inc;
    logic               sector_done;
    logic               wr_advance;

    // Descending scan so the lowest requesting drive is the one left selected.
    always_comb begin
        req_any = 1'b0;
        req_drv = 2'd0;
        req_rd  = 1'b0;
        req_lba = 32'd0;
        req_img = 32'd0;
        for (int d = VDNUM - 1; d >= 0; d--) begin
            if (sd_rd[d] | sd_wr[d]) begin
                req_any = 1'b1;
                req_drv = 2'(d);
                req_rd  = sd_rd[d];
                req_lba = sd_lba[32*d +: 32];
                req_img = img_blocks[32*d +: 32];
            end
        end
        din_sel    = 8'd0;
        drv_onehot = '0;
        for (int d = 0; d < VDNUM; d++) begin
            if (drv == 2'(d)) begin
                din_sel       = sd_buff_din[8*d +: 8];
                drv_onehot[d] = 1'b1;
            end
        end
    end

    assign addr_inc = sd_buff_addr + 9'd1;

    always_comb begin
        state_nxt        = state;
        drv_nxt          = drv;
        is_rd_nxt        = is_rd;
        lba_nxt          = lba;
        inrange_nxt      = inrange;
        cnt_nxt          = cnt;
        sd_ack_nxt       = sd_ack;
        sd_buff_addr_nxt = sd_buff_addr;
        sd_buff_dout_nxt = sd_buff_dout;
        sd_buff_wr_nxt   = 1'b0;
        mem_addr_nxt     = mem_addr;
        mem_rd_nxt       = mem_rd;
        mem_wr_nxt       = mem_wr;
        mem_din_nxt      = mem_din;
        sector_done      = 1'b0;
        wr_advance       = 1'b0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    drv_nxt     = req_drv;
                    is_rd_nxt   = req_rd;
                    lba_nxt     = req_lba[LBA_W-1:0];
                    inrange_nxt = (req_lba < req_img);
                    cnt_nxt     = CNT_LOAD;
                    state_nxt   = DELAY;
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    sd_ack_nxt       = drv_onehot;
                    sd_buff_addr_nxt = 9'd0;
                    if (is_rd) begin
                        mem_rd_nxt   = inrange;
                        mem_addr_nxt = {drv, lba, 9'd0};
                        state_nxt    = RFETCH;
                    end else begin
                        state_nxt    = WADDR;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RFETCH: begin
                if (!inrange) begin
                    sd_buff_dout_nxt = 8'h00;
                    sd_buff_wr_nxt   = 1'b1;
                    state_nxt        = RPUT;
                end else if (mem_ready) begin
                    sd_buff_dout_nxt = mem_dout;
                    sd_buff_wr_nxt   = 1'b1;
                    mem_rd_nxt       = 1'b0;
                    state_nxt        = RPUT;
                end
            end
            RPUT: begin
                if (sd_buff_addr == LAST) begin
                    sector_done = 1'b1;
                end else begin
                    sd_buff_addr_nxt = addr_inc;
                    mem_rd_nxt       = inrange;
                    mem_addr_nxt     = {drv, lba, addr_inc};
                    state_nxt        = RFETCH;
                end
            end
            WADDR: state_nxt = WCAP;
            WCAP: begin
                mem_din_nxt = din_sel;
                if (inrange) begin
                    mem_wr_nxt   = 1'b1;
                    mem_addr_nxt = {drv, lba, sd_buff_addr};
                    state_nxt    = WPUT;
                end else begin
                    wr_advance = 1'b1;
                end
            end
            WPUT: begin
                if (mem_ready) begin
                    mem_wr_nxt = 1'b0;
                    wr_advance = 1'b1;
                end
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (wr_advance) begin
            if (sd_buff_addr == LAST) begin
                sector_done = 1'b1;
            end else begin
                sd_buff_addr_nxt = addr_inc;
                state_nxt        = WADDR;
            end
        end

        // Ack drops on entry to FIN so it is low for FIN and IDLE before any new accept.
        if (sector_done) begin
            sd_ack_nxt       = '0;
            sd_buff_addr_nxt = 9'd0;
            state_nxt        = FIN;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            drv          <= 2'd0;
            is_rd        <= 1'b0;
            lba          <= '0;
            inrange      <= 1'b0;
            cnt          <= '0;
            sd_ack       <= '0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'd0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_din      <= 8'd0;
        end else begin
            state        <= state_nxt;
            drv          <= drv_nxt;
            is_rd        <= is_rd_nxt;
            lba          <= lba_nxt;
            inrange      <= inrange_nxt;
            cnt          <= cnt_nxt;
            sd_ack       <= sd_ack_nxt;
            sd_buff_addr <= sd_buff_addr_nxt;
            sd_buff_dout <= sd_buff_dout_nxt;
            sd_buff_wr   <= sd_buff_wr_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_rd       <= mem_rd_nxt;
            mem_wr       <= mem_wr_nxt;
            mem_din      <= mem_din_nxt;
        end
    end

endmodule

// File: tb/tb_sd_sector_server.sv
// Bench for sd_sector_server: directed protocol scenarios plus randomized sectors,
// checked against a byte-level model of what each sector must produce.
module tb_sd_sector_server;

    localparam int VDNUM     = 2;
    localparam int LBA_W     = 15;
    localparam int ACK_DELAY = 4;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic [63:0]  sd_lba;
    logic [1:0]   sd_rd;
    logic [1:0]   sd_wr;
    logic [1:0]   sd_ack;
    logic [8:0]   sd_buff_addr;
    logic [7:0]   sd_buff_dout;
    logic [15:0]  sd_buff_din = '0;
    logic         sd_buff_wr;
    logic [63:0]  img_blocks;
    logic [25:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout = '0;
    logic         mem_ready = 1'b0;

    sd_sector_server #(.VDNUM(VDNUM), .LBA_W(LBA_W), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .img_blocks(img_blocks),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         errors = 0;
    int         mem_lat = 2;
    logic [7:0] rkey = 8'h00;
    logic [7:0] wkey0 = 8'h00;
    logic [7:0] wkey1 = 8'h00;
    int         mcnt = 0;

    // Backing store: byte at address a reads as a[7:0]^rkey, completes mem_lat cycles after request.
    always @(posedge clk_sys) begin
        mem_ready <= 1'b0;
        if ((mem_rd || mem_wr) && !mem_ready) begin
            if (mcnt >= mem_lat - 1) begin
                mem_ready <= 1'b1;
                mcnt      <= 0;
                mem_dout  <= mem_addr[7:0] ^ rkey;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // Initiator buffer: registered, lane d returns ~addr ^ wkey_d one cycle later.
    always @(posedge clk_sys)
        sd_buff_din <= {~sd_buff_addr[7:0] ^ wkey1, ~sd_buff_addr[7:0] ^ wkey0};

    logic [16:0] rd_q[$];
    logic [25:0] mrd_q[$];
    logic [33:0] mwr_q[$];
    int          ack_order[$];
    int          ack_rises = 0;
    int          mrd_cycles = 0;
    int          both_cnt = 0;
    int          twohot = 0;
    logic [1:0]  ack_prev = 2'b00;
    int          clr_req = 0;
    int          clr_seen = 0;

    always @(negedge clk_sys) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            rd_q.delete();
            mrd_q.delete();
            mwr_q.delete();
            ack_order.delete();
            ack_rises  = 0;
            mrd_cycles = 0;
        end
        if (sd_buff_wr) rd_q.push_back({sd_buff_addr, sd_buff_dout});
        if (mem_rd) mrd_cycles++;
        if (mem_rd && mem_ready) mrd_q.push_back(mem_addr);
        if (mem_wr && mem_ready) mwr_q.push_back({mem_addr, mem_din});
        if (mem_rd && mem_wr) both_cnt++;
        if (sd_ack[0] && sd_ack[1]) twohot++;
        for (int d = 0; d < 2; d++) begin
            if (sd_ack[d] && !ack_prev[d]) begin
                ack_rises++;
                ack_order.push_back(d);
            end
        end
        ack_prev = sd_ack;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        clr_req++;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic run_sector(input string tag, input int d, input bit rd,
                              input logic [31:0] lba, output int lat);
        int n;
        n = 0;
        sd_lba[32*d +: 32] = lba;
        if (rd) sd_rd[d] = 1'b1;
        else    sd_wr[d] = 1'b1;
        while (sd_ack[d] !== 1'b1 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        lat = n;
        sd_rd[d] = 1'b0;
        sd_wr[d] = 1'b0;
        chk({tag, "_ack_rise"}, sd_ack[d], 1'b1);
        n = 0;
        while (sd_ack[d] !== 1'b0 && n < 20000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_ack_fall"}, sd_ack[d], 1'b0);
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic check_read(input string tag, input int d, input logic [31:0] lba,
                              input logic [31:0] img, input logic [7:0] key);
        bit         inr;
        int         bad;
        logic [7:0] ed;
        inr = (lba < img);
        bad = 0;
        chk({tag, "_pulses"}, rd_q.size(), 512);
        for (int i = 0; i < rd_q.size() && i < 512; i++) begin
            ed = inr ? (8'(i) ^ key) : 8'h00;
            if (rd_q[i] !== {9'(i), ed}) bad++;
        end
        chk({tag, "_data_bad"}, bad, 0);
        if (inr) begin
            bad = 0;
            chk({tag, "_mem_reads"}, mrd_q.size(), 512);
            for (int i = 0; i < mrd_q.size() && i < 512; i++)
                if (mrd_q[i] !== {2'(d), lba[LBA_W-1:0], 9'(i)}) bad++;
            chk({tag, "_mem_addr_bad"}, bad, 0);
        end else begin
            chk({tag, "_mem_rd_cycles"}, mrd_cycles, 0);
        end
    endtask

    task automatic check_write(input string tag, input int d, input logic [31:0] lba,
                               input logic [31:0] img, input logic [7:0] key);
        bit inr;
        int bad;
        inr = (lba < img);
        bad = 0;
        chk({tag, "_no_buff_wr"}, rd_q.size(), 0);
        chk({tag, "_mem_writes"}, mwr_q.size(), inr ? 512 : 0);
        for (int i = 0; i < mwr_q.size() && i < 512; i++)
            if (mwr_q[i] !== {2'(d), lba[LBA_W-1:0], 9'(i), ~8'(i) ^ key}) bad++;
        chk({tag, "_write_bad"}, bad, 0);
    endtask

    initial begin
        int lat;
        int n;
        int rises;
        int bad;
        logic prev;
        int d;
        bit rd;
        logic [31:0] lba;
        logic [31:0] img;

        reset = 1'b1;
        sd_rd = '0;
        sd_wr = '0;
        sd_lba = '0;
        img_blocks = '0;
        repeat (3) @(negedge clk_sys);
        chk("reset_outputs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                              mem_rd, mem_wr, mem_addr, mem_din}, 64'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Basic read, drive 0, lba 5 of 10
        img_blocks[31:0] = 32'd10;
        rkey = 8'h5A;
        mem_lat = 2;
        clear_mon();
        run_sector("rd0", 0, 1'b1, 32'd5, lat);
        chk("rd0_ack_latency", lat, ACK_DELAY + 1);
        check_read("rd0", 0, 32'd5, 32'd10, 8'h5A);

        // Floppy-style multi-sector read
        img_blocks[31:0] = 32'd100;
        rkey = 8'h11;
        mem_lat = 1;
        clear_mon();
        sd_lba[31:0] = 32'd0;
        sd_rd[0] = 1'b1;
        n = 0;
        rises = 0;
        prev = 1'b0;
        while (!(rises == 13 && sd_ack[0] == 1'b0) && n < 40000) begin
            @(negedge clk_sys);
            n++;
            if (sd_ack[0] && !prev) begin
                rises++;
                sd_lba[31:0] = sd_lba[31:0] + 32'd1;
                if (rises == 13) sd_rd[0] = 1'b0;
            end
            prev = sd_ack[0];
        end
        sd_rd[0] = 1'b0;
        repeat (60) @(negedge clk_sys);
        chk("floppy_ack_rises", ack_rises, 13);
        chk("floppy_pulses", rd_q.size(), 13 * 512);
        bad = 0;
        for (int j = 0; j < rd_q.size(); j++)
            if (rd_q[j] !== {9'(j % 512), 8'(j % 512) ^ 8'h11}) bad++;
        chk("floppy_data_bad", bad, 0);
        bad = 0;
        for (int j = 0; j < mrd_q.size(); j++)
            if (mrd_q[j] !== {2'd0, 15'(j / 512), 9'(j % 512)}) bad++;
        chk("floppy_mem_reads", mrd_q.size(), 13 * 512);
        chk("floppy_lba_seq_bad", bad, 0);

        // Write, drive 1, lba 3
        img_blocks[63:32] = 32'd50;
        wkey1 = 8'h00;
        mem_lat = 2;
        clear_mon();
        run_sector("wr1", 1, 1'b0, 32'd3, lat);
        check_write("wr1", 1, 32'd3, 32'd50, 8'h00);

        // Out-of-range read at the image boundary
        img_blocks[31:0] = 32'd10;
        clear_mon();
        run_sector("oor_rd", 0, 1'b1, 32'd10, lat);
        check_read("oor_rd", 0, 32'd10, 32'd10, 8'h00);

        // Write to an unmounted drive
        img_blocks[63:32] = 32'd0;
        clear_mon();
        run_sector("unmnt_wr", 1, 1'b0, 32'd7, lat);
        chk("unmnt_wr_ack_pulses", ack_rises, 1);
        check_write("unmnt_wr", 1, 32'd7, 32'd0, 8'h00);

        // Full 32-bit unsigned compare, upper LBA bits ignored for addressing
        img_blocks[31:0] = 32'h0002_0000;
        rkey = 8'hC3;
        clear_mon();
        run_sector("big_lba", 0, 1'b1, 32'h0001_0005, lat);
        check_read("big_lba", 0, 32'h0001_0005, 32'h0002_0000, 8'hC3);
        img_blocks[31:0] = 32'h7FFF_FFFF;
        clear_mon();
        run_sector("msb_lba", 0, 1'b1, 32'h8000_0000, lat);
        check_read("msb_lba", 0, 32'h8000_0000, 32'h7FFF_FFFF, 8'hC3);

        // Simultaneous drive-1 read and drive-0 write
        img_blocks = {32'd20, 32'd20};
        sd_lba = {32'd4, 32'd2};
        wkey0 = 8'h3C;
        rkey = 8'h0F;
        clear_mon();
        sd_wr[0] = 1'b1;
        sd_rd[1] = 1'b1;
        n = 0;
        while (!(ack_rises >= 2 && sd_ack == 2'b00) && n < 12000) begin
            @(negedge clk_sys);
            n++;
            if (sd_ack[0]) sd_wr[0] = 1'b0;
            if (sd_ack[1]) sd_rd[1] = 1'b0;
        end
        sd_wr = '0;
        sd_rd = '0;
        repeat (6) @(negedge clk_sys);
        chk("arb_ack_rises", ack_rises, 2);
        chk("arb_first_drive", (ack_order.size() >= 1) ? ack_order[0] : -1, 0);
        chk("arb_second_drive", (ack_order.size() >= 2) ? ack_order[1] : -1, 1);
        chk("arb_mem_writes", mwr_q.size(), 512);
        chk("arb_mem_reads", mrd_q.size(), 512);
        chk("arb_read_pulses", rd_q.size(), 512);

        // Reset in the middle of a read
        img_blocks[31:0] = 32'd10;
        rkey = 8'h77;
        mem_lat = 2;
        clear_mon();
        sd_lba[31:0] = 32'd1;
        sd_rd[0] = 1'b1;
        n = 0;
        while (sd_ack[0] !== 1'b1 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        sd_rd[0] = 1'b0;
        n = 0;
        while (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'd200) && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("rst_reached_byte200", sd_buff_addr, 9'd200);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rst_outputs_zero", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                                 mem_rd, mem_wr, mem_addr, mem_din}, 64'd0);
        reset = 1'b0;
        clear_mon();
        repeat (20) @(negedge clk_sys);
        chk("rst_quiet_pulses", rd_q.size(), 0);
        chk("rst_quiet_mem_rd", mrd_cycles, 0);
        chk("rst_quiet_ack", ack_rises, 0);
        clear_mon();
        run_sector("rst_fresh", 0, 1'b1, 32'd2, lat);
        check_read("rst_fresh", 0, 32'd2, 32'd10, 8'h77);

        // Randomized sectors
        for (int k = 0; k < 4; k++) begin
            d = int'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            img = 32'($urandom_range(1, 40));
            lba = 32'($urandom_range(0, 50));
            mem_lat = int'($urandom_range(1, 3));
            rkey = 8'($urandom);
            if (d == 0) wkey0 = 8'($urandom);
            else        wkey1 = 8'($urandom);
            img_blocks[32*d +: 32] = img;
            clear_mon();
            run_sector("rnd", d, rd, lba, lat);
            chk("rnd_ack_latency", lat, ACK_DELAY + 1);
            if (rd) check_read("rnd_rd", d, lba, img, rkey);
            else    check_write("rnd_wr", d, lba, img, (d == 0) ? wkey0 : wkey1);
        end

        chk("never_rd_and_wr", both_cnt, 0);
        chk("never_two_hot_ack", twohot, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
